// File: rtl/fml_vtx_capture.sv
// Passive retire-trace monitor beside the COP; emits one vtx_* record per retired instruction.
// Optional EXEC watchdog enabled by defining FML_VTX_TIMEOUT_EN.
module fml_vtx_capture #(
  parameter int unsigned NTXN           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               cpu_insn_req,
  input  logic               cop_insn_ack,
  input  logic [31:0]        cpu_insn_enc,
  input  logic [31:0]        cpu_rs1,
  input  logic               cop_insn_rsp,
  input  logic               cpu_insn_ack,
  input  logic [2:0]         cop_result,
  input  logic               cop_wen,
  input  logic [4:0]         cop_waddr,
  input  logic [31:0]        cop_wdata,
  input  logic               cop_mem_cen,
  input  logic               cop_mem_wen,
  input  logic [31:0]        cop_mem_addr,
  input  logic [31:0]        cop_mem_wdata,
  input  logic [3:0]         cop_mem_ben,
  input  logic               cop_mem_stall,
  input  logic [31:0]        cop_mem_rdata,
  input  logic               cop_mem_error,
  input  logic [511:0]       cprs_flat,
  input  logic [31:0]        rand_sample,
  output logic               vtx_valid,
  output logic [31:0]        vtx_instr_enc,
  output logic [31:0]        vtx_instr_rs1,
  output logic [2:0]         vtx_instr_result,
  output logic               vtx_instr_wen,
  output logic [4:0]         vtx_instr_waddr,
  output logic [31:0]        vtx_instr_wdata,
  output logic [NTXN-1:0]    vtx_mem_cen,
  output logic [NTXN-1:0]    vtx_mem_wen,
  output logic [NTXN*32-1:0] vtx_mem_addr,
  output logic [NTXN*32-1:0] vtx_mem_wdata,
  output logic [NTXN*32-1:0] vtx_mem_rdata,
  output logic [NTXN*4-1:0]  vtx_mem_ben,
  output logic [NTXN-1:0]    vtx_mem_error,
  output logic [511:0]       vtx_cprs_pre,
  output logic [511:0]       vtx_cprs_post,
  output logic [31:0]        vtx_rand_sample,
  output logic               vtx_proto_err,
  output logic               vtx_mem_ovf,
  output logic               vtx_timeout
);

  localparam int unsigned   CW       = $clog2(NTXN + 1);
  localparam int unsigned   IW       = (NTXN > 1) ? $clog2(NTXN) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(NTXN);

  typedef enum logic [1:0] {IDLE, EXEC, POST} state_t;

  state_t        state_q, state_d;
  logic          req_hs, rsp_hs, start, finish, mem_acc, mem_win;
  logic          slot_fill, ovf_set, perr_set;
  logic [CW-1:0] cnt_q, cnt_base;
  logic [IW-1:0] fill_idx, pend_idx_q;
  logic          pend_q;

  logic [31:0]  w_enc, w_rs1, w_rand, w_wdata;
  logic [2:0]   w_result;
  logic         w_wen;
  logic [4:0]   w_waddr;
  logic [511:0] w_pre;

  logic        s_cen   [NTXN];
  logic        s_wen   [NTXN];
  logic [31:0] s_addr  [NTXN];
  logic [31:0] s_wdata [NTXN];
  logic [31:0] s_rdata [NTXN];
  logic [3:0]  s_ben   [NTXN];
  logic        s_err   [NTXN];

  assign req_hs  = cpu_insn_req & cop_insn_ack;
  assign rsp_hs  = cop_insn_rsp & cpu_insn_ack;
  assign mem_acc = cop_mem_cen & ~cop_mem_stall;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A request in IDLE/POST together with a response is a complete 0-cycle instruction.
  always_comb begin
    state_d  = state_q;
    start    = req_hs & (state_q != EXEC);
    finish   = rsp_hs & ((state_q == EXEC) | start);
    mem_win  = (state_q == EXEC) | finish;
    cnt_base = start ? '0 : cnt_q;
    fill_idx = IW'(cnt_base);
    slot_fill = mem_acc & mem_win & (cnt_base != CNT_FULL);
    ovf_set   = mem_acc & mem_win & (cnt_base == CNT_FULL);
    perr_set  = (rsp_hs & (state_q == IDLE) & ~req_hs)
              | (req_hs & (state_q == EXEC))
              | (mem_acc & (state_q == IDLE) & ~finish);
    case (state_q)
      IDLE, POST: begin
        if (start)                 state_d = finish ? POST : EXEC;
        else if (state_q == POST)  state_d = IDLE;
      end
      EXEC:    if (rsp_hs) state_d = POST;
      default: state_d = IDLE;
    endcase
  end

  // Late rdata lands first, a new instruction's clear overrides it, a new fill overrides both.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_q <= '0; pend_q <= 1'b0; pend_idx_q <= '0;
      w_enc <= '0; w_rs1 <= '0; w_rand <= '0; w_pre <= '0;
      w_result <= '0; w_wen <= 1'b0; w_waddr <= '0; w_wdata <= '0;
      for (int unsigned k = 0; k < NTXN; k++) begin
        s_cen[k] <= 1'b0; s_wen[k] <= 1'b0; s_addr[k] <= '0; s_wdata[k] <= '0;
        s_rdata[k] <= '0; s_ben[k] <= '0; s_err[k] <= 1'b0;
      end
    end else begin
      pend_q     <= slot_fill;
      pend_idx_q <= fill_idx;
      if (pend_q) begin
        s_rdata[pend_idx_q] <= cop_mem_rdata;
        s_err[pend_idx_q]   <= cop_mem_error;
      end
      if (start) begin
        w_enc <= cpu_insn_enc; w_rs1 <= cpu_rs1; w_pre <= cprs_flat; w_rand <= rand_sample;
        cnt_q <= '0;
        for (int unsigned k = 0; k < NTXN; k++) begin
          s_cen[k] <= 1'b0; s_wen[k] <= 1'b0; s_addr[k] <= '0; s_wdata[k] <= '0;
          s_rdata[k] <= '0; s_ben[k] <= '0; s_err[k] <= 1'b0;
        end
      end
      if (finish) begin
        w_result <= cop_result; w_wen <= cop_wen; w_waddr <= cop_waddr; w_wdata <= cop_wdata;
      end
      if (slot_fill) begin
        s_cen[fill_idx]   <= 1'b1;
        s_wen[fill_idx]   <= cop_mem_wen;
        s_addr[fill_idx]  <= cop_mem_addr;
        s_wdata[fill_idx] <= cop_mem_wdata;
        s_ben[fill_idx]   <= cop_mem_ben;
        cnt_q             <= cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      vtx_valid <= 1'b0;
      vtx_instr_enc <= '0; vtx_instr_rs1 <= '0; vtx_instr_result <= '0;
      vtx_instr_wen <= 1'b0; vtx_instr_waddr <= '0; vtx_instr_wdata <= '0;
      vtx_mem_cen <= '0; vtx_mem_wen <= '0; vtx_mem_addr <= '0; vtx_mem_wdata <= '0;
      vtx_mem_rdata <= '0; vtx_mem_ben <= '0; vtx_mem_error <= '0;
      vtx_cprs_pre <= '0; vtx_cprs_post <= '0; vtx_rand_sample <= '0;
    end else begin
      vtx_valid <= (state_q == POST);
      if (state_q == POST) begin
        vtx_instr_enc <= w_enc; vtx_instr_rs1 <= w_rs1; vtx_instr_result <= w_result;
        vtx_instr_wen <= w_wen; vtx_instr_waddr <= w_waddr; vtx_instr_wdata <= w_wdata;
        vtx_cprs_pre <= w_pre; vtx_cprs_post <= cprs_flat; vtx_rand_sample <= w_rand;
        for (int unsigned k = 0; k < NTXN; k++) begin
          vtx_mem_cen[k]            <= s_cen[k];
          vtx_mem_wen[k]            <= s_wen[k];
          vtx_mem_addr[k*32 +: 32]  <= s_addr[k];
          vtx_mem_wdata[k*32 +: 32] <= s_wdata[k];
          vtx_mem_ben[k*4 +: 4]     <= s_ben[k];
          // The last transaction of the response cycle returns its data during POST.
          if (pend_q && (pend_idx_q == IW'(k))) begin
            vtx_mem_rdata[k*32 +: 32] <= cop_mem_rdata;
            vtx_mem_error[k]          <= cop_mem_error;
          end else begin
            vtx_mem_rdata[k*32 +: 32] <= s_rdata[k];
            vtx_mem_error[k]          <= s_err[k];
          end
        end
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      vtx_proto_err <= 1'b0;
      vtx_mem_ovf   <= 1'b0;
    end else begin
      if (perr_set) vtx_proto_err <= 1'b1;
      if (ovf_set)  vtx_mem_ovf   <= 1'b1;
    end
  end

`ifdef FML_VTX_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      tmo_cnt_q   <= '0;
      vtx_timeout <= 1'b0;
    end else if (state_q == EXEC) begin
      if (tmo_cnt_q != '1)       tmo_cnt_q   <= tmo_cnt_q + 1'b1;
      if (tmo_cnt_q >= TMO_LAST) vtx_timeout <= 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign vtx_timeout = 1'b0;
`endif

endmodule
